// File: rtl/cache_route_dispatch.sv
// Clocked front end of the 6-way cache route selector: buffers requests, decodes a one-hot
// route, and hands each one to the selector over a 2-phase drive/fire/free handshake.
module cache_route_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_hit,
  input  logic             req_write,
  input  logic             req_dirty,
  input  logic             req_flush,
  output logic [5:0]       o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_drive,
  input  logic             i_fire,
  input  logic             i_free,
  output logic             o_busy,
  output logic             o_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = TAG_W + 4;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic           TMO_EN   = (TIMEOUT > 0) ? 1'b1 : 1'b0;
  localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TW-1:0]  TMO_ONE  = TW'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SETUP     = 2'd1;
  localparam logic [1:0] WAIT_FIRE = 2'd2;
  localparam logic [1:0] WAIT_FREE = 2'd3;

  logic [1:0]       state_r, state_next_s;
  logic [EW-1:0]    mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r, count_next_s;
  logic             ready_r, busy_r;
  logic [5:0]       valid_r, valid_next_s;
  logic [TAG_W-1:0] tag_r, tag_next_s;
  logic             drive_r, drive_next_s;
  logic             err_r, err_next_s;
  logic [TW-1:0]    tmo_cnt_r, tmo_next_s;
  logic [1:0]       fire_sync_r, free_sync_r;
  logic             fire_hist_r, free_hist_r;
  logic             push_s, pop_s, fire_ev_s, free_ev_s, tmo_hit_s;
  logic [EW-1:0]    head_s;

  // Route priority: flush wins, then hits split by direction, then dirty-victim misses.
  function automatic logic [5:0] decode_route(input logic hit, input logic write,
                                              input logic dirty, input logic flush);
    if (flush)               return 6'b100000;
    else if (hit && !write)  return 6'b000001;
    else if (hit && write)   return 6'b000010;
    else if (dirty)          return 6'b001000;
    else if (!write)         return 6'b000100;
    else                     return 6'b010000;
  endfunction

  // Next-state, FIFO occupancy and handshake event decode.
  always_comb begin
    push_s       = req_valid & ready_r;
    pop_s        = (state_r == IDLE) && (count_r != '0);
    head_s       = mem_r[rd_ptr_r];
    fire_ev_s    = fire_sync_r[1] ^ fire_hist_r;
    free_ev_s    = free_sync_r[1] ^ free_hist_r;
    tmo_hit_s    = TMO_EN && (tmo_cnt_r == TMO_LAST);
    state_next_s = state_r;
    valid_next_s = valid_r;
    tag_next_s   = tag_r;
    drive_next_s = drive_r;
    err_next_s   = err_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          valid_next_s = decode_route(head_s[3], head_s[2], head_s[1], head_s[0]);
          tag_next_s   = head_s[EW-1:4];
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        drive_next_s = ~drive_r;
        state_next_s = WAIT_FIRE;
      end
      WAIT_FIRE: begin
        // A free seen alongside its fire completes the whole handshake at once.
        if (fire_ev_s && free_ev_s) begin
          valid_next_s = 6'b000000;
          tag_next_s   = '0;
          state_next_s = IDLE;
        end else if (fire_ev_s) begin
          state_next_s = WAIT_FREE;
        end else if (tmo_hit_s) begin
          err_next_s   = 1'b1;
          valid_next_s = 6'b000000;
          tag_next_s   = '0;
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_FIRE;
        end
      end
      WAIT_FREE: begin
        if (free_ev_s || tmo_hit_s) begin
          err_next_s   = err_r | (tmo_hit_s & ~free_ev_s);
          valid_next_s = 6'b000000;
          tag_next_s   = '0;
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_FREE;
        end
      end
      default: begin
        valid_next_s = 6'b000000;
        tag_next_s   = '0;
        state_next_s = IDLE;
      end
    endcase
    if (state_next_s != state_r) begin
      tmo_next_s = '0;
    end else if ((state_r == WAIT_FIRE) || (state_r == WAIT_FREE)) begin
      tmo_next_s = tmo_cnt_r + TMO_ONE;
    end else begin
      tmo_next_s = '0;
    end
  end

  // State, FIFO storage, synchronizers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      valid_r     <= 6'b000000;
      tag_r       <= '0;
      drive_r     <= 1'b0;
      err_r       <= 1'b0;
      tmo_cnt_r   <= '0;
      fire_sync_r <= 2'b00;
      free_sync_r <= 2'b00;
      fire_hist_r <= 1'b0;
      free_hist_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {req_tag, req_hit, req_write, req_dirty, req_flush};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      state_r     <= state_next_s;
      count_r     <= count_next_s;
      ready_r     <= (count_next_s != FULL_CNT);
      busy_r      <= (state_next_s != IDLE);
      valid_r     <= valid_next_s;
      tag_r       <= tag_next_s;
      drive_r     <= drive_next_s;
      err_r       <= err_next_s;
      tmo_cnt_r   <= tmo_next_s;
      fire_sync_r <= {fire_sync_r[0], i_fire};
      free_sync_r <= {free_sync_r[0], i_free};
      fire_hist_r <= fire_sync_r[1];
      free_hist_r <= free_sync_r[1];
    end
  end

  assign req_ready = ready_r;
  assign o_valid   = valid_r;
  assign o_tag     = tag_r;
  assign o_drive   = drive_r;
  assign o_busy    = busy_r;
  assign o_err     = err_r;

endmodule
